// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-stage controller: access size encodings,
// controller state encoding, and helpers for byte-lane masks, alignment masks
// and load-result extension.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } mem_state_e;

    localparam logic [7:0] TIMEOUT_CNT_MAX = 8'd255;

    // Unshifted byte-lane mask for an access of the given size.
    function automatic logic [7:0] size_lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for the access to be naturally aligned.
    function automatic logic [2:0] size_align_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'b000;
            SZ_HALF: return 3'b001;
            SZ_WORD: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Sign- or zero-extend a right-aligned load value to 64 bits.
    function automatic logic [63:0] extend_load(input logic [63:0] v,
                                                input logic [1:0]  size,
                                                input logic        uns);
        case (size)
            SZ_BYTE: return uns ? {56'b0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
            SZ_HALF: return uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            SZ_WORD: return uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed lane(s) of the read bus and
// extends the value to the full data width. Purely combinational.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LB     = (DATA_W == 64) ? 3 : 2
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [LB-1:0]     offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] shifted;
    logic [63:0]       wide;
    logic [63:0]       ext;

    // Shift the addressed byte lane down to bit 0, then extend per size.
    always_comb begin
        shifted  = data_i >> {offset_i, 3'b000};
        wide     = 64'(shifted);
        ext      = extend_load(wide, size_i, unsigned_i);
        result_o = DATA_W'(ext);
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns a load/store in the MEM pipeline stage into a
// held request to data memory, stalls upstream until ACK or timeout, and
// returns an aligned, extended load result with a one-cycle completion pulse.
// Handshake: MEM_outMREQ and all request outputs stay stable from the first REQ
// cycle until MEM_inACK is sampled high (or the timeout fires); ACK outside REQ
// is ignored.
// Optional feature macro: MEM_MISALIGN_TRAP_EN adds MEM_outMISALIGN and rejects
// misaligned accesses; without it the low address bits are truncated.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                MEM_inCLK,
    input  logic                MEM_inRESET_N,
    input  logic                MEM_inVALID,
    input  logic                MEM_inMEMWRITE,
    input  logic                MEM_inMEMREAD,
    input  logic [1:0]          MEM_inSIZE,
    input  logic                MEM_inUNSIGNED,
    input  logic [ADDR_W-1:0]   MEM_inADDRESS,
    input  logic [DATA_W-1:0]   MEM_inWRITEDATA,
    input  logic                MEM_inACK,
    input  logic [DATA_W-1:0]   MEM_inLOADDATA,
    output logic                MEM_outMREQ,
    output logic                MEM_outWRITE,
    output logic [1:0]          MEM_outSIZE,
    output logic [ADDR_W-1:0]   MEM_outADDRESS,
    output logic [DATA_W-1:0]   MEM_outWRITEDATA,
    output logic [DATA_W/8-1:0] MEM_outBYTEEN,
    output logic                MEM_outSTALL,
    output logic [DATA_W-1:0]   MEM_outRESULT,
    output logic                MEM_outRESULTVALID,
    output logic                MEM_outBUSERR
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                MEM_outMISALIGN
`endif
);

    localparam int         NB           = DATA_W / 8;
    localparam int         LB           = (DATA_W == 64) ? 3 : 2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    mem_state_e          state_q;
    logic [7:0]          cnt_q;
    logic                mreq_q, write_q, unsigned_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, result_q;
    logic [NB-1:0]       byteen_q;
    logic                resultvalid_q, buserr_q;

    logic                access_req, can_accept, accept;
    logic [ADDR_W-1:0]   align_bits, addr_d;
    logic [NB-1:0]       byteen_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   load_result;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                misaligned, misalign_q;
`endif

    // Decide whether a new access is taken this cycle and prepare its fields.
    always_comb begin
        access_req = MEM_inRESET_N & MEM_inVALID & (MEM_inMEMREAD | MEM_inMEMWRITE);
        can_accept = (state_q != S_REQ);
        align_bits = ADDR_W'(size_align_mask(MEM_inSIZE));
        addr_d     = MEM_inADDRESS & ~align_bits;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = |(MEM_inADDRESS & align_bits);
        accept     = can_accept & access_req & ~misaligned;
`else
        accept     = can_accept & access_req;
`endif
        byteen_d   = NB'(size_lane_mask(MEM_inSIZE)) << addr_d[LB-1:0];
    end

    // Replicate right-aligned store data across every lane group of its size.
    always_comb begin
        wdata_d = '0;
        for (int i = 0; i < NB; i++) begin
            case (MEM_inSIZE)
                SZ_BYTE: wdata_d[i*8 +: 8] = MEM_inWRITEDATA[7:0];
                SZ_HALF: wdata_d[i*8 +: 8] = MEM_inWRITEDATA[(i % 2)*8 +: 8];
                SZ_WORD: wdata_d[i*8 +: 8] = MEM_inWRITEDATA[(i % 4)*8 +: 8];
                default: wdata_d[i*8 +: 8] = MEM_inWRITEDATA[i*8 +: 8];
            endcase
        end
    end

    mem_load_align #(
        .DATA_W (DATA_W),
        .LB     (LB)
    ) u_load_align (
        .data_i     (MEM_inLOADDATA),
        .offset_i   (addr_q[LB-1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .result_o   (load_result)
    );

    // Controller FSM with registered request, result and pulse outputs.
    always_ff @(posedge MEM_inCLK or negedge MEM_inRESET_N) begin
        if (!MEM_inRESET_N) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mreq_q        <= 1'b0;
            write_q       <= 1'b0;
            unsigned_q    <= 1'b0;
            size_q        <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= '0;
            byteen_q      <= '0;
            result_q      <= '0;
            resultvalid_q <= 1'b0;
            buserr_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            resultvalid_q <= 1'b0;
            buserr_q      <= 1'b0;
            case (state_q)
                S_REQ: begin
                    if (MEM_inACK) begin
                        state_q       <= S_DONE;
                        mreq_q        <= 1'b0;
                        resultvalid_q <= 1'b1;
                        if (!write_q) result_q <= load_result;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q  <= S_IDLE;
                        mreq_q   <= 1'b0;
                        buserr_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (cnt_q != TIMEOUT_CNT_MAX) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            // A new access may be taken from IDLE or DONE (back-to-back).
            if (accept) begin
                state_q    <= S_REQ;
                cnt_q      <= '0;
                mreq_q     <= 1'b1;
                write_q    <= MEM_inMEMWRITE;
                unsigned_q <= MEM_inUNSIGNED;
                size_q     <= MEM_inSIZE;
                addr_q     <= addr_d;
                wdata_q    <= wdata_d;
                byteen_q   <= byteen_d;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= can_accept & access_req & misaligned;
`endif
        end
    end

    // Stall while a request is outstanding and in the cycle an access is taken.
    always_comb begin
        MEM_outSTALL = (state_q == S_REQ) | accept;
    end

    assign MEM_outMREQ        = mreq_q;
    assign MEM_outWRITE       = write_q;
    assign MEM_outSIZE        = size_q;
    assign MEM_outADDRESS     = addr_q;
    assign MEM_outWRITEDATA   = wdata_q;
    assign MEM_outBYTEEN      = byteen_q;
    assign MEM_outRESULT      = result_q;
    assign MEM_outRESULTVALID = resultvalid_q;
    assign MEM_outBUSERR      = buserr_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign MEM_outMISALIGN    = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (ADDR_W=32, DATA_W=32, TIMEOUT=4).
module tb_mem_stage_ctrl;

    logic        clk, rst_n;
    logic        valid, mwrite, mread, uns, ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, ldata;
    logic        mreq, write, stall, rvalid, buserr;
    logic [1:0]  osize;
    logic [31:0] oaddr, owdata, result;
    logic [3:0]  byteen;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .MEM_inCLK          (clk),
        .MEM_inRESET_N      (rst_n),
        .MEM_inVALID        (valid),
        .MEM_inMEMWRITE     (mwrite),
        .MEM_inMEMREAD      (mread),
        .MEM_inSIZE         (size),
        .MEM_inUNSIGNED     (uns),
        .MEM_inADDRESS      (addr),
        .MEM_inWRITEDATA    (wdata),
        .MEM_inACK          (ack),
        .MEM_inLOADDATA     (ldata),
        .MEM_outMREQ        (mreq),
        .MEM_outWRITE       (write),
        .MEM_outSIZE        (osize),
        .MEM_outADDRESS     (oaddr),
        .MEM_outWRITEDATA   (owdata),
        .MEM_outBYTEEN      (byteen),
        .MEM_outSTALL       (stall),
        .MEM_outRESULT      (result),
        .MEM_outRESULTVALID (rvalid),
        .MEM_outBUSERR      (buserr)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .MEM_outMISALIGN    (misalign)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_access(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic u, input logic [31:0] a, input logic [31:0] d);
        valid  = 1'b1;
        mread  = rd;
        mwrite = wr;
        size   = sz;
        uns    = u;
        addr   = a;
        wdata  = d;
    endtask

    task automatic drive_none();
        valid  = 1'b0;
        mread  = 1'b0;
        mwrite = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        drive_none();
        size = 2'b00; uns = 1'b0; addr = '0; wdata = '0; ack = 1'b0; ldata = '0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mreq", 64'(mreq), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_buserr", 64'(buserr), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_addr", 64'(oaddr), 64'd0);
        check_eq("rst_byteen", 64'(byteen), 64'd0);
        check_eq("rst_size", 64'(osize), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Signed byte load at offset 3, ACK on the second REQ cycle.
        drive_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
        ldata = 32'h80FF_FFFF;
        @(negedge clk);
        check_eq("t1_stall_accept", 64'(stall), 64'd1);
        check_eq("t1_mreq_accept", 64'(mreq), 64'd0);
        step(); drive_none();
        @(negedge clk);
        check_eq("t1_mreq", 64'(mreq), 64'd1);
        check_eq("t1_byteen", 64'(byteen), 64'h8);
        check_eq("t1_addr", 64'(oaddr), 64'h1003);
        check_eq("t1_write", 64'(write), 64'd0);
        step(); ack = 1'b1;
        @(negedge clk);
        check_eq("t1_mreq_c2", 64'(mreq), 64'd1);
        check_eq("t1_rvalid_early", 64'(rvalid), 64'd0);
        step(); ack = 1'b0;
        @(negedge clk);
        check_eq("t1_rvalid", 64'(rvalid), 64'd1);
        check_eq("t1_result", 64'(result), 64'hFFFF_FF80);
        check_eq("t1_stall_done", 64'(stall), 64'd0);
        check_eq("t1_mreq_done", 64'(mreq), 64'd0);
        step();
        @(negedge clk);
        check_eq("t1_rvalid_pulse", 64'(rvalid), 64'd0);

        // Half store with both READ and WRITE set (treated as store).
        step();
        drive_access(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
        step(); drive_none();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("t2_mreq_held", 64'(mreq), 64'd1);
            check_eq("t2_wdata", 64'(owdata), 64'hBEEF_BEEF);
            check_eq("t2_byteen", 64'(byteen), 64'hC);
            check_eq("t2_write", 64'(write), 64'd1);
            step();
            if (c == 1) ack = 1'b1;
        end
        ack = 1'b0;
        @(negedge clk);
        check_eq("t2_rvalid", 64'(rvalid), 64'd1);
        check_eq("t2_result_held", 64'(result), 64'hFFFF_FF80);

        // Timeout: no ACK for 4 REQ cycles.
        step();
        drive_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        step(); drive_none();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("t3_mreq_wait", 64'(mreq), 64'd1);
            check_eq("t3_buserr_wait", 64'(buserr), 64'd0);
            step();
        end
        @(negedge clk);
        check_eq("t3_buserr", 64'(buserr), 64'd1);
        check_eq("t3_mreq_drop", 64'(mreq), 64'd0);
        check_eq("t3_stall", 64'(stall), 64'd0);
        check_eq("t3_rvalid", 64'(rvalid), 64'd0);
        check_eq("t3_result_kept", 64'(result), 64'hFFFF_FF80);
        step();
        @(negedge clk);
        check_eq("t3_buserr_pulse", 64'(buserr), 64'd0);

        // ACK on the TIMEOUT-th cycle wins.
        drive_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0);
        ldata = 32'h1234_5678;
        step(); drive_none();
        for (int c = 0; c < 3; c++) step();
        ack = 1'b1;
        step(); ack = 1'b0;
        @(negedge clk);
        check_eq("t4_rvalid", 64'(rvalid), 64'd1);
        check_eq("t4_buserr", 64'(buserr), 64'd0);
        check_eq("t4_result", 64'(result), 64'h1234_5678);

        // Reset in the middle of a request, VALID still high.
        step();
        drive_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_4003, 32'h0);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_mreq", 64'(mreq), 64'd0);
        check_eq("t5_stall", 64'(stall), 64'd0);
        check_eq("t5_addr", 64'(oaddr), 64'd0);
        check_eq("t5_byteen", 64'(byteen), 64'd0);
        check_eq("t5_result", 64'(result), 64'd0);
        check_eq("t5_write", 64'(write), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_none();
        ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("t5_no_rvalid", 64'(rvalid), 64'd0);
            check_eq("t5_no_mreq", 64'(mreq), 64'd0);
            step();
        end
        ack = 1'b0;

        // Back-to-back loads, zero-wait memory.
        drive_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_4001, 32'h0);
        step(); drive_none();
        ack = 1'b1; ldata = 32'h0000_AB00;
        @(negedge clk);
        check_eq("t6_mreq_a", 64'(mreq), 64'd1);
        step(); ack = 1'b0;
        drive_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0);
        @(negedge clk);
        check_eq("t6_rvalid_a", 64'(rvalid), 64'd1);
        check_eq("t6_result_a", 64'(result), 64'h0000_00AB);
        check_eq("t6_stall_b", 64'(stall), 64'd1);
        step(); drive_none();
        ack = 1'b1; ldata = 32'h8001_0000;
        @(negedge clk);
        check_eq("t6_gap", 64'(rvalid), 64'd0);
        check_eq("t6_mreq_b", 64'(mreq), 64'd1);
        step(); ack = 1'b0;
        @(negedge clk);
        check_eq("t6_rvalid_b", 64'(rvalid), 64'd1);
        check_eq("t6_result_b", 64'(result), 64'hFFFF_8001);

        // Byte store replication.
        step();
        drive_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h0000_005A);
        step(); drive_none();
        @(negedge clk);
        check_eq("t7_wdata", 64'(owdata), 64'h5A5A_5A5A);
        check_eq("t7_byteen", 64'(byteen), 64'h2);
        step(); ack = 1'b1;
        step(); ack = 1'b0;
        step();

        // Misaligned word load.
        drive_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5001, 32'h0);
        ldata = 32'hCAFE_F00D;
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        check_eq("t8_stall", 64'(stall), 64'd0);
        step(); drive_none();
        @(negedge clk);
        check_eq("t8_misalign", 64'(misalign), 64'd1);
        check_eq("t8_mreq", 64'(mreq), 64'd0);
        step();
        @(negedge clk);
        check_eq("t8_misalign_pulse", 64'(misalign), 64'd0);
        check_eq("t8_mreq_never", 64'(mreq), 64'd0);
`else
        step(); drive_none();
        @(negedge clk);
        check_eq("t8_addr_trunc", 64'(oaddr), 64'h5000);
        check_eq("t8_byteen", 64'(byteen), 64'hF);
        check_eq("t8_mreq", 64'(mreq), 64'd1);
        step(); ack = 1'b1;
        step(); ack = 1'b0;
        @(negedge clk);
        check_eq("t8_result", 64'(result), 64'hCAFE_F00D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
